// File: rtl/bit_reverse_stream.sv
// Message buffer that captures up to DEPTH words, then streams them back out,
// optionally mirroring the bits of each word and/or reversing the word order.
module bit_reverse_stream #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic [ADDR_W:0]   msg_len,
  output logic              trunc
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN_RD, DRAIN} state_t;

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   idx_sel;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_word;
  logic              in_fire;
  logic              out_fire;
  logic              fill_done;
  logic              load_last;

  function automatic logic [WIDTH-1:0] mirror(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fill_done = in_fire && (in_last || (state == FILL && wr_cnt == LAST_SLOT));
  assign wr_addr   = (state == IDLE) ? '0 : wr_cnt[ADDR_W-1:0];

  // Index of the word being loaded into the output register: the current one
  // on the first load of a drain, the following one after each handshake.
  assign idx_sel   = out_valid ? rd_idx + ONE : rd_idx;
  assign rd_addr   = mode_q[1] ? ADDR_W'(msg_len - ONE - idx_sel) : idx_sel[ADDR_W-1:0];
  assign rd_word   = mem[rd_addr];
  assign load_last = (idx_sel == msg_len - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (in_fire) state_next = in_last ? DRAIN_RD : FILL;
      FILL:     if (fill_done) state_next = DRAIN_RD;
      DRAIN_RD: state_next = DRAIN;
      DRAIN:    if (out_fire && out_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) || (state == FILL);
  end

  // Storage is deliberately left out of reset; stale words are never read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt    <= '0;
      rd_idx    <= '0;
      mode_q    <= '0;
      msg_len   <= '0;
      trunc     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (in_fire) begin
            mode_q <= mode;
            wr_cnt <= ONE;
          end
        end
        FILL: begin
          if (in_fire) begin
            wr_cnt <= wr_cnt + ONE;
            if (wr_cnt == LAST_SLOT && !in_last) begin
              trunc <= 1'b1;
            end
          end
        end
        DRAIN_RD: begin
          msg_len <= wr_cnt;
          rd_idx  <= '0;
        end
        DRAIN: begin
          // Output register only moves when empty or when its word is taken.
          if (!out_valid || out_fire) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
            end else begin
              out_data  <= mode_q[0] ? mirror(rd_word) : rd_word;
              out_last  <= load_last;
              out_valid <= 1'b1;
              rd_idx    <= idx_sel;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_reverse_stream.sv
// Directed bench for bit_reverse_stream: a queue-based message model checked
// every cycle, plus literal expected word lists for each scenario.
module tb_bit_reverse_stream;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic [ADDR_W:0]   msg_len;
  logic              trunc;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] stim_words [16];
  logic [7:0] lit [16];
  int         lit_n;
  int         checks = 0;
  int         errors = 0;
  bit         rand_ready = 1'b0;

  bit_reverse_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .msg_len   (msg_len),
    .trunc     (trunc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] mirror_model(input logic [7:0] w);
    logic [7:0] r;
    r = {<<{w}};
    return r;
  endfunction

  // Builds the expected output sequence from the message, then feeds it in.
  task automatic applyStimulus(input logic [1:0] m, input int n, input bit use_last, input bit toggle);
    exp_t e;
    int   idx;
    int   guard;
    bit   exp_trunc;
    exp_trunc = !use_last && (n == DEPTH);
    for (int k = 0; k < n; k++) begin
      idx    = m[1] ? n - 1 - k : k;
      e.data = m[0] ? mirror_model(stim_words[idx]) : stim_words[idx];
      e.last = (k == n - 1);
      e.len  = n;
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stim_words[k];
      in_last  = use_last && (k == n - 1);
      mode     = (toggle && k > 0) ? ~m : m;
      guard    = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("trunc_after_last", 32'(trunc), 32'(exp_trunc));
    checkOutput("latency_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_edge1b", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_edge2", 32'(out_valid), 32'd1);
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic checkWords(input string name);
    checkOutput({name, "_count"}, 32'(obs_q.size()), 32'(lit_n));
    for (int i = 0; i < lit_n; i++) begin
      if (i < obs_q.size()) begin
        checkOutput($sformatf("%s_word%0d", name, i), 32'(obs_q[i]), 32'(lit[i]));
      end
    end
    obs_q.delete();
  endtask

  // Consumer-side driver: changes only just after a rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(1, 0) != 0) : 1'b1;
    end
  end

  // Per-cycle compare against the model queue, plus hold-stability rules.
  initial begin
    bit         prev_valid;
    bit         prev_ready;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_data", 32'(out_data), 32'(prev_data));
          checkOutput("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid) begin
          checkOutput("in_ready_in_drain", 32'(in_ready), 32'd0);
          checkOutput("trunc_in_drain", 32'(trunc), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out: got data %0h expected no word", out_data);
          end else begin
            checkOutput("out_data", 32'(out_data), 32'(exp_q[0].data));
            checkOutput("out_last", 32'(out_last), 32'(exp_q[0].last));
            checkOutput("msg_len", 32'(msg_len), 32'(exp_q[0].len));
            if (out_ready) begin
              obs_q.push_back(out_data);
              void'(exp_q.pop_front());
            end
          end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    reset    = 1'b0;
    mode     = 2'b00;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_msg_len", 32'(msg_len), 32'd0);
    checkOutput("rst_trunc", 32'(trunc), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] test 1: pass-through");
    stim_words[0] = 8'h01; stim_words[1] = 8'h02; stim_words[2] = 8'h04; stim_words[3] = 8'h80;
    applyStimulus(2'b00, 4, 1'b1, 1'b0);
    waitDrain();
    lit[0] = 8'h01; lit[1] = 8'h02; lit[2] = 8'h04; lit[3] = 8'h80; lit_n = 4;
    checkWords("t1");
    checkOutput("t1_msg_len_held", 32'(msg_len), 32'd4);

    $display("[TB] test 2: mirror, mode toggled mid-message");
    stim_words[0] = 8'h01; stim_words[1] = 8'hA0; stim_words[2] = 8'h0F;
    applyStimulus(2'b01, 3, 1'b1, 1'b1);
    waitDrain();
    lit[0] = 8'h80; lit[1] = 8'h05; lit[2] = 8'hF0; lit_n = 3;
    checkWords("t2");

    $display("[TB] test 3: mirror and reverse");
    stim_words[0] = 8'h12; stim_words[1] = 8'h34;
    applyStimulus(2'b11, 2, 1'b1, 1'b0);
    waitDrain();
    lit[0] = 8'h2C; lit[1] = 8'h48; lit_n = 2;
    checkWords("t3");

    $display("[TB] test 4: truncation at full depth");
    for (int i = 0; i < 16; i++) begin
      stim_words[i] = 8'(i);
      lit[i]        = 8'(i);
    end
    lit_n = 16;
    applyStimulus(2'b00, 16, 1'b0, 1'b0);
    waitDrain();
    checkWords("t4");
    stim_words[0] = 8'h55;
    applyStimulus(2'b00, 1, 1'b1, 1'b0);
    waitDrain();
    lit[0] = 8'h55; lit_n = 1;
    checkWords("t4_next");

    $display("[TB] test 5: single word with random backpressure");
    rand_ready = 1'b1;
    stim_words[0] = 8'hA5;
    applyStimulus(2'b10, 1, 1'b1, 1'b0);
    waitDrain();
    rand_ready = 1'b0;
    lit[0] = 8'hA5; lit_n = 1;
    checkWords("t5");

    $display("[TB] test 6: reset during drain");
    stim_words[0] = 8'h11; stim_words[1] = 8'h22; stim_words[2] = 8'h33; stim_words[3] = 8'h44;
    applyStimulus(2'b00, 4, 1'b1, 1'b0);
    #1;
    guard = 0;
    while (obs_q.size() < 1 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("t6_first_word_seen", 32'(obs_q.size()), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_out_last", 32'(out_last), 32'd0);
    checkOutput("t6_rst_out_data", 32'(out_data), 32'd0);
    checkOutput("t6_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t6_rst_msg_len", 32'(msg_len), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    #1;
    checkOutput("t6_release_in_ready", 32'(in_ready), 32'd1);
    stim_words[0] = 8'h3C;
    applyStimulus(2'b01, 1, 1'b1, 1'b0);
    waitDrain();
    lit[0] = 8'h3C; lit_n = 1;
    checkWords("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
